alu_op_sequencer: RTL and testbench

- Initiator-side front end for the combinational 8-bit ALU (x, y, m, s in; 16-bit z out).
- Accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Issues one command per ALU evaluation, registers the 16-bit result and returns it with its tag over a valid/ready response stream.
- Optional chaining feeds the previous result's low byte back as the next x operand.

---
 rtl/alu_op_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command front end for a combinational 8-bit ALU: buffers tagged operations in a FIFO,
// issues them one at a time and returns each registered 16-bit result with its tag.
module alu_op_sequencer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_x,
   input  logic [7:0]       cmd_y,
   input  logic [1:0]       cmd_m,
   input  logic [1:0]       cmd_s,
   input  logic             cmd_chain,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [7:0]       alu_x,
   output logic [7:0]       alu_y,
   output logic [1:0]       alu_m,
   output logic [1:0]       alu_s,
   input  logic [15:0]      alu_z,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_z,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy,
   output logic [15:0]      op_count
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [7:0]       x;
      logic [7:0]       y;
      logic [1:0]       m;
      logic [1:0]       s;
      logic             chain;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   // Command FIFO
   cmd_t          fifo_mem [DEPTH];
   cmd_t          cmd_in;
   cmd_t          head;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;

   // Sequencer state
   state_t           state_q;
   logic [7:0]       op_x_q;
   logic [7:0]       op_y_q;
   logic [1:0]       op_m_q;
   logic [1:0]       op_s_q;
   logic [TAG_W-1:0] op_tag_q;
   logic [7:0]       op_x_d;
   logic [7:0]       last_low_q;
   logic             rsp_valid_q;
   logic [15:0]      rsp_z_q;
   logic [TAG_W-1:0] rsp_tag_q;
   logic [15:0]      op_count_q;

   assign cmd_in = '{x: cmd_x, y: cmd_y, m: cmd_m, s: cmd_s, chain: cmd_chain, tag: cmd_tag};

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign push       = cmd_valid && !fifo_full;
   // The FIFO is popped exactly when the sequencer is free to load a new operation.
   assign pop        = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
   assign head       = fifo_mem[rd_ptr_q];

   // Only the low byte of the last result is ever fed back as a chained operand.
   assign op_x_d = head.chain ? last_low_q : head.x;

   // NOTE: the storage array is deliberately not reset; entries are only read behind
   // count_q, so clearing the pointers and count is enough to flush the FIFO.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= cmd_in;
      end
   end

   // NOTE: sequential state always uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order within the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_x_q      <= '0;
         op_y_q      <= '0;
         op_m_q      <= '0;
         op_s_q      <= '0;
         op_tag_q    <= '0;
         last_low_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_z_q     <= '0;
         rsp_tag_q   <= '0;
         op_count_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  op_x_q   <= op_x_d;
                  op_y_q   <= head.y;
                  op_m_q   <= head.m;
                  op_s_q   <= head.s;
                  op_tag_q <= head.tag;
                  state_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               rsp_z_q     <= alu_z;
               last_low_q  <= alu_z[7:0];
               rsp_tag_q   <= op_tag_q;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  op_count_q  <= op_count_q + 16'd1;
                  if (pop) begin
                     op_x_q   <= op_x_d;
                     op_y_q   <= head.y;
                     op_m_q   <= head.m;
                     op_s_q   <= head.s;
                     op_tag_q <= head.tag;
                     state_q  <= S_ISSUE;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = !fifo_full;
   assign alu_x     = op_x_q;
   assign alu_y     = op_y_q;
   assign alu_m     = op_m_q;
   assign alu_s     = op_s_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_z     = rsp_z_q;
   assign rsp_tag   = rsp_tag_q;
   assign op_count  = op_count_q;
   assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: XOR-stub ALU, randomized commands, in-order response
// reference model computed from the command stream.
module tb_alu_op_sequencer;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [7:0]       cmd_x;
   logic [7:0]       cmd_y;
   logic [1:0]       cmd_m;
   logic [1:0]       cmd_s;
   logic             cmd_chain;
   logic [TAG_W-1:0] cmd_tag;
   logic [7:0]       alu_x;
   logic [7:0]       alu_y;
   logic [1:0]       alu_m;
   logic [1:0]       alu_s;
   logic [15:0]      alu_z;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [15:0]      rsp_z;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;
   logic [15:0]      op_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit stop_toggle;

   typedef struct {
      logic [15:0]      z;
      logic [TAG_W-1:0] tag;
      int               c;
   } rsp_t;

   rsp_t       exp_q[$];
   rsp_t       got_q[$];
   logic [7:0] model_last;

   alu_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_m(cmd_m), .cmd_s(cmd_s),
      .cmd_chain(cmd_chain), .cmd_tag(cmd_tag),
      .alu_x(alu_x), .alu_y(alu_y), .alu_m(alu_m), .alu_s(alu_s), .alu_z(alu_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_tag(rsp_tag),
      .busy(busy), .op_count(op_count)
   );

   // Combinational ALU stand-in
   assign alu_z = {alu_x, alu_y} ^ {12'h000, alu_s, alu_m};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         got_q.push_back('{z: rsp_z, tag: rsp_tag, c: cyc});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      exp_q.delete();
      got_q.delete();
      model_last = 8'h00;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Drives one command until accepted; the expected response is derived at acceptance.
   task automatic send_cmd(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m,
                           input logic [1:0] s, input logic chain,
                           input logic [TAG_W-1:0] tag, output int acc);
      bit          done;
      logic [7:0]  xe;
      logic [15:0] z;
      done      = 1'b0;
      acc       = -1;
      cmd_x     = x;
      cmd_y     = y;
      cmd_m     = m;
      cmd_s     = s;
      cmd_chain = chain;
      cmd_tag   = tag;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            done       = 1'b1;
            acc        = cyc;
            xe         = chain ? model_last : x;
            z          = {xe, y} ^ {12'h000, s, m};
            model_last = z[7:0];
            exp_q.push_back('{z: z, tag: tag, c: 0});
         end
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL cmd_accept tag=%0d: no cmd_ready within 200 cycles, expected acceptance", tag);
      end
   endtask

   task automatic wait_rsp(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (got_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      rst_n     = 1'b0;
      model_clear();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl ready/valid/busy=%b%b%b expected 100", cmd_ready, rsp_valid, busy);
      end
      checks++;
      if (op_count !== 16'h0 || rsp_z !== 16'h0 || rsp_tag !== '0) begin
         errors++;
         $display("FAIL reset_rsp op_count=%h rsp_z=%h rsp_tag=%h expected all zero", op_count, rsp_z, rsp_tag);
      end
      checks++;
      if ({alu_x, alu_y, alu_m, alu_s} !== 20'h0) begin
         errors++;
         $display("FAIL reset_alu alu bus=%h expected 0", {alu_x, alu_y, alu_m, alu_s});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_single();
      int   acc;
      bit   ok;
      rsp_t e, g;
      do_reset();
      rsp_ready = 1'b1;
      send_cmd(8'h12, 8'h34, 2'd1, 2'd2, 1'b0, 4'd5, acc);
      wait_rsp(1, 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_timeout got %0d responses expected 1", got_q.size());
      end else begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g.c !== acc + 3) begin
            errors++;
            $display("FAIL single_latency rsp cycle=%0d expected %0d", g.c, acc + 3);
         end
         checks++;
         if (g.z !== e.z || g.tag !== e.tag) begin
            errors++;
            $display("FAIL single_data z=%h tag=%0d expected z=%h tag=%0d", g.z, g.tag, e.z, e.tag);
         end
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || op_count !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after rsp_valid=%b op_count=%0d busy=%b expected 0 1 0", rsp_valid, op_count, busy);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_chain();
      int   acc;
      bit   ok;
      rsp_t e, g;
      do_reset();
      rsp_ready = 1'b1;
      send_cmd(8'hAB, 8'h01, 2'd0, 2'd0, 1'b0, 4'd1, acc);
      send_cmd(8'hFF, 8'h02, 2'd3, 2'd1, 1'b1, 4'd2, acc);
      wait_rsp(2, 40, ok);
      checks++;
      if (!ok || got_q.size() != 2) begin
         errors++;
         $display("FAIL chain_count got %0d responses expected 2", got_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g.z !== e.z || g.tag !== e.tag) begin
            errors++;
            $display("FAIL chain_data z=%h tag=%0d expected z=%h tag=%0d", g.z, g.tag, e.z, e.tag);
         end
      end
   endtask

   task automatic test_backpressure();
      int          acc;
      int          h;
      bit          ok;
      bit          stall_bad;
      logic [15:0] z0;
      rsp_t        e, g;
      logic [7:0]  x6, y6;
      do_reset();
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_cmd(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  4'(i), acc);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_full cmd_ready=%b rsp_valid=%b expected 0 1", cmd_ready, rsp_valid);
      end
      z0        = rsp_z;
      x6        = 8'($urandom);
      y6        = 8'($urandom);
      cmd_x     = x6;
      cmd_y     = y6;
      cmd_m     = 2'd2;
      cmd_s     = 2'd3;
      cmd_chain = 1'b1;
      cmd_tag   = 4'd5;
      cmd_valid = 1'b1;
      stall_bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_z !== z0) stall_bad = 1'b1;
      end
      checks++;
      if (stall_bad) begin
         errors++;
         $display("FAIL bp_stall held values changed: cmd_ready=%b rsp_valid=%b rsp_z=%h expected 0 1 %h",
                  cmd_ready, rsp_valid, rsp_z, z0);
      end
      checks++;
      if (z0 !== exp_q[0].z) begin
         errors++;
         $display("FAIL bp_first_z rsp_z=%h expected %h", z0, exp_q[0].z);
      end
      @(posedge clk);
      #1;
      h         = cyc;
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_pop_cycle cmd_ready=%b expected 0 in the popping cycle", cmd_ready);
      end
      send_cmd(x6, y6, 2'd2, 2'd3, 1'b1, 4'd5, acc);
      checks++;
      if (acc !== h + 1) begin
         errors++;
         $display("FAIL bp_ready_rise accept cycle=%0d expected %0d", acc, h + 1);
      end
      wait_rsp(6, 100, ok);
      checks++;
      if (!ok || got_q.size() != 6 || op_count !== 16'd6) begin
         errors++;
         $display("FAIL bp_count responses=%0d op_count=%0d expected 6 6", got_q.size(), op_count);
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g.z !== e.z || g.tag !== e.tag) begin
            errors++;
            $display("FAIL bp_data z=%h tag=%0d expected z=%h tag=%0d", g.z, g.tag, e.z, e.tag);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   acc;
      bit   ok;
      rsp_t e, g;
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send_cmd(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  4'(i + 8), acc);
      end
      wait_rsp(8, 200, ok);
      checks++;
      if (!ok || got_q.size() != 8) begin
         errors++;
         $display("FAIL b2b_count got %0d responses expected 8", got_q.size());
      end
      for (int i = 1; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i].c - got_q[i-1].c != 2) begin
            errors++;
            $display("FAIL b2b_gap response %0d spacing=%0d expected 2", i, got_q[i].c - got_q[i-1].c);
         end
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g.z !== e.z || g.tag !== e.tag) begin
            errors++;
            $display("FAIL b2b_data z=%h tag=%0d expected z=%h tag=%0d", g.z, g.tag, e.z, e.tag);
         end
      end
   endtask

   task automatic test_reset_mid();
      int   acc;
      bit   ok;
      bit   seen;
      rsp_t e, g;
      do_reset();
      rsp_ready = 1'b1;
      send_cmd(8'h3C, 8'hC3, 2'd1, 2'd1, 1'b0, 4'd7, acc);
      wait_rsp(1, 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mid_pre got %0d responses expected 1", got_q.size());
      end else begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g.z !== e.z || op_count !== 16'd1) begin
            errors++;
            $display("FAIL mid_pre_data z=%h op_count=%0d expected z=%h op_count=1", g.z, op_count, e.z);
         end
      end
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_cmd(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), 1'b0, 4'(i), acc);
      end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (rsp_valid === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL mid_resp rsp_valid never rose, expected RESP with queued entries");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 16'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset rsp_valid=%b cmd_ready=%b op_count=%0d busy=%b expected 0 1 0 0",
                  rsp_valid, cmd_ready, op_count, busy);
      end
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (got_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_stale responses=%0d busy=%b expected 0 0", got_q.size(), busy);
      end
   endtask

   task automatic test_chain_after_reset();
      int   acc;
      bit   ok;
      rsp_t g;
      do_reset();
      rsp_ready = 1'b1;
      send_cmd(8'($urandom), 8'h55, 2'd0, 2'd0, 1'b1, 4'd9, acc);
      wait_rsp(1, 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL chain0_timeout got %0d responses expected 1", got_q.size());
      end else begin
         g = got_q.pop_front();
         void'(exp_q.pop_front());
         checks++;
         if (g.z !== 16'h0055 || g.tag !== 4'd9) begin
            errors++;
            $display("FAIL chain0_data z=%h tag=%0d expected z=0055 tag=9", g.z, g.tag);
         end
      end
   endtask

   task automatic test_random();
      int   acc;
      bit   ok;
      rsp_t e, g;
      do_reset();
      stop_toggle = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               send_cmd(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                        1'($urandom_range(0, 1)), 4'($urandom), acc);
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            wait_rsp(40, 2000, ok);
            stop_toggle = 1'b1;
         end
         begin
            while (!stop_toggle) begin
               @(posedge clk);
               #1 rsp_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (!ok || got_q.size() != 40 || op_count !== 16'd40) begin
         errors++;
         $display("FAIL rand_count responses=%0d op_count=%0d expected 40 40", got_q.size(), op_count);
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g.z !== e.z || g.tag !== e.tag) begin
            errors++;
            $display("FAIL rand_data z=%h tag=%0d expected z=%h tag=%0d", g.z, g.tag, e.z, e.tag);
         end
      end
   endtask

   initial begin
      cmd_valid = 1'b0;
      cmd_x     = '0;
      cmd_y     = '0;
      cmd_m     = '0;
      cmd_s     = '0;
      cmd_chain = 1'b0;
      cmd_tag   = '0;
      rsp_ready = 1'b0;
      #2;
      test_reset();
      test_single();
      test_chain();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_chain_after_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
